// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the pipelined main control unit: RV32 opcodes the
// decoder recognises, the ALUOp encodings handed to the ALU control block,
// and the packed control bundle that travels down the pipeline.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

   // Opcodes decoded by the main control
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_SB   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   // ALUOp encodings; ALUOP_I tells ALU control to use funct3 in immediate
   // form so that shifts such as slli pick up the right operation.
   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   // Control bundle produced in ID and carried through ID/EX
   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       link;
   } ctrl_t;

   // A bubble does nothing anywhere in the pipe
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_control_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_control_unit_if
// Bundles the ID-stage instruction fields, the EX redirect, and all of the
// per-stage control outputs of pipe_control_unit.
//   master : drives id_* and ex_redirect, observes stage controls
//   slave  : the control unit itself
// ---------------------------------------------------------------------------
interface pipe_control_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 2
);

   logic [6:0]            id_opcode;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  ex_redirect;

   logic [ALUOP_W-1:0]    ex_alu_op;
   logic                  ex_alu_src;
   logic                  ex_branch;
   logic                  ex_jump;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_illegal;

   logic                  mem_mem_read;
   logic                  mem_mem_write;
   logic [REG_ADDR_W-1:0] mem_rd;

   logic                  wb_reg_write;
   logic                  wb_mem_to_reg;
   logic                  wb_link;
   logic [REG_ADDR_W-1:0] wb_rd;

   logic                  pc_write;
   logic                  ifid_write;
   logic                  ifid_flush;

   modport master (
      output id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
      input  ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_rd, ex_illegal,
      input  mem_mem_read, mem_mem_write, mem_rd,
      input  wb_reg_write, wb_mem_to_reg, wb_link, wb_rd,
      input  pc_write, ifid_write, ifid_flush
   );

   modport slave (
      input  id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
      output ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_rd, ex_illegal,
      output mem_mem_read, mem_mem_write, mem_rd,
      output wb_reg_write, wb_mem_to_reg, wb_link, wb_rd,
      output pc_write, ifid_write, ifid_flush
   );

endinterface

// File: rtl/ctrl_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_decoder
// Purely combinational main decoder: opcode -> control bundle, plus an
// illegal flag and which source registers the instruction really reads
// (the hazard unit must not stall on a register field that is only
// immediate bits).
// Ports:
//   i_opcode    in  7   opcode of the ID instruction
//   o_ctrl      out     ctrl_t bundle (regWrite not yet qualified by rd)
//   o_illegal   out 1   opcode not recognised (or jump while disabled)
//   o_uses_rs1  out 1   instruction reads rs1
//   o_uses_rs2  out 1   instruction reads rs2
// ---------------------------------------------------------------------------
module ctrl_decoder
   import ctrl_pkg::*;
#(
   parameter int ENABLE_JUMP = 1
) (
   input  logic [6:0] i_opcode,
   output ctrl_t      o_ctrl,
   output logic       o_illegal,
   output logic       o_uses_rs1,
   output logic       o_uses_rs2
);

   // Every path starts from a bubble so unrecognised opcodes leave all
   // controls low; only the illegal flag distinguishes them from a NOP.
   always_comb begin
      o_ctrl     = CTRL_BUBBLE;
      o_illegal  = 1'b0;
      o_uses_rs1 = 1'b0;
      o_uses_rs2 = 1'b0;
      case (i_opcode)
         OP_R: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_op    = ALUOP_R;
            o_uses_rs1       = 1'b1;
            o_uses_rs2       = 1'b1;
         end
         OP_LD: begin
            o_ctrl.mem_read   = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.alu_src    = 1'b1;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_uses_rs1        = 1'b1;
         end
         OP_IALU: begin
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_op    = ALUOP_I;
            o_uses_rs1       = 1'b1;
         end
         OP_SD: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_uses_rs1       = 1'b1;
            o_uses_rs2       = 1'b1;
         end
         OP_SB: begin
            o_ctrl.branch = 1'b1;
            o_ctrl.alu_op = ALUOP_BR;
            o_uses_rs1    = 1'b1;
            o_uses_rs2    = 1'b1;
         end
         OP_JAL: begin
            if (ENABLE_JUMP != 0) begin
               o_ctrl.jump      = 1'b1;
               o_ctrl.reg_write = 1'b1;
               o_ctrl.link      = 1'b1;
               o_ctrl.alu_src   = 1'b1;
               o_ctrl.alu_op    = ALUOP_ADD;
            end else begin
               o_illegal = 1'b1;
            end
         end
         OP_JALR: begin
            if (ENABLE_JUMP != 0) begin
               o_ctrl.jump      = 1'b1;
               o_ctrl.reg_write = 1'b1;
               o_ctrl.link      = 1'b1;
               o_ctrl.alu_src   = 1'b1;
               o_ctrl.alu_op    = ALUOP_ADD;
               o_uses_rs1       = 1'b1;
            end else begin
               o_illegal = 1'b1;
            end
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/pipe_control_unit.sv
// ---------------------------------------------------------------------------
// pipe_control_unit
// Pipelined main control: decodes the ID opcode, carries the controls
// through ID/EX, EX/MEM and MEM/WB, detects load-use hazards (stall PC and
// IF/ID, bubble into ID/EX) and squashes the wrong path on an EX redirect.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous active-high reset
//   bus    slave modport of pipe_control_unit_if
//          in : id_opcode, id_rs1, id_rs2, id_rd, ex_redirect
//          out: ex_* (EX stage), mem_* (MEM stage), wb_* (WB stage),
//               pc_write / ifid_write / ifid_flush (combinational)
// ---------------------------------------------------------------------------
module pipe_control_unit
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int ALUOP_W     = 2,
   parameter int ENABLE_JUMP = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   pipe_control_unit_if.slave      bus
);

   ctrl_t                 w_dec_ctrl;
   ctrl_t                 w_id_ctrl;
   logic                  w_dec_illegal;
   logic                  w_uses_rs1;
   logic                  w_uses_rs2;
   logic                  w_stall;
   logic                  w_flush;
   logic                  w_bubble;

   ctrl_t                 r_ex_ctrl;
   logic [REG_ADDR_W-1:0] r_ex_rd;
   logic                  r_ex_illegal;

   logic                  r_mem_mem_read;
   logic                  r_mem_mem_write;
   logic                  r_mem_reg_write;
   logic                  r_mem_mem_to_reg;
   logic                  r_mem_link;
   logic [REG_ADDR_W-1:0] r_mem_rd;

   logic                  r_wb_reg_write;
   logic                  r_wb_mem_to_reg;
   logic                  r_wb_link;
   logic [REG_ADDR_W-1:0] r_wb_rd;

   ctrl_decoder #(
      .ENABLE_JUMP (ENABLE_JUMP)
   ) u_decoder (
      .i_opcode   (bus.id_opcode),
      .o_ctrl     (w_dec_ctrl),
      .o_illegal  (w_dec_illegal),
      .o_uses_rs1 (w_uses_rs1),
      .o_uses_rs2 (w_uses_rs2)
   );

   // Writes to x0 are architecturally discarded, so drop regWrite early;
   // downstream forwarding logic can then trust reg_write alone.
   always_comb begin
      w_id_ctrl = w_dec_ctrl;
      if (bus.id_rd == '0) begin
         w_id_ctrl.reg_write = 1'b0;
      end
   end

   // Load-use hazard: the load in EX produces its data too late for the
   // instruction in ID. Only registers the ID instruction actually reads
   // count, and a load to x0 never creates a dependency.
   always_comb begin
      w_stall = r_ex_ctrl.mem_read && (r_ex_rd != '0) &&
                ((w_uses_rs1 && (bus.id_rs1 == r_ex_rd)) ||
                 (w_uses_rs2 && (bus.id_rs2 == r_ex_rd)));
      w_flush  = bus.ex_redirect;
      w_bubble = w_stall || w_flush;
   end

   // Front-end control. A redirect overrides any stall because the stalled
   // instruction is on the wrong path anyway. Reset forces the front end to
   // run so nothing stale in ID/EX can freeze it while the pipe is cleared.
   always_comb begin
      bus.pc_write   = reset || w_flush || !w_stall;
      bus.ifid_write = reset || w_flush || !w_stall;
      bus.ifid_flush = !reset && w_flush;
   end

   // ID/EX register: loads the decoded instruction unless it must be
   // replaced by a bubble (stall, squash or reset).
   always_ff @(posedge clk) begin
      if (reset || w_bubble) begin
         r_ex_ctrl    <= CTRL_BUBBLE;
         r_ex_rd      <= '0;
         r_ex_illegal <= 1'b0;
      end else begin
         r_ex_ctrl    <= w_id_ctrl;
         r_ex_rd      <= bus.id_rd;
         r_ex_illegal <= w_dec_illegal;
      end
   end

   // EX/MEM register: always advances, keeps only MEM and WB controls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_mem_read   <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_link       <= 1'b0;
         r_mem_rd         <= '0;
      end else begin
         r_mem_mem_read   <= r_ex_ctrl.mem_read;
         r_mem_mem_write  <= r_ex_ctrl.mem_write;
         r_mem_reg_write  <= r_ex_ctrl.reg_write;
         r_mem_mem_to_reg <= r_ex_ctrl.mem_to_reg;
         r_mem_link       <= r_ex_ctrl.link;
         r_mem_rd         <= r_ex_rd;
      end
   end

   // MEM/WB register: always advances, keeps only WB controls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_reg_write  <= 1'b0;
         r_wb_mem_to_reg <= 1'b0;
         r_wb_link       <= 1'b0;
         r_wb_rd         <= '0;
      end else begin
         r_wb_reg_write  <= r_mem_reg_write;
         r_wb_mem_to_reg <= r_mem_mem_to_reg;
         r_wb_link       <= r_mem_link;
         r_wb_rd         <= r_mem_rd;
      end
   end

   // Stage outputs straight from the stage registers
   always_comb begin
      bus.ex_alu_op     = ALUOP_W'(r_ex_ctrl.alu_op);
      bus.ex_alu_src    = r_ex_ctrl.alu_src;
      bus.ex_branch     = r_ex_ctrl.branch;
      bus.ex_jump       = r_ex_ctrl.jump;
      bus.ex_rd         = r_ex_rd;
      bus.ex_illegal    = r_ex_illegal;
      bus.mem_mem_read  = r_mem_mem_read;
      bus.mem_mem_write = r_mem_mem_write;
      bus.mem_rd        = r_mem_rd;
      bus.wb_reg_write  = r_wb_reg_write;
      bus.wb_mem_to_reg = r_wb_mem_to_reg;
      bus.wb_link       = r_wb_link;
      bus.wb_rd         = r_wb_rd;
   end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined successor to the single-cycle main control decoder for the RISC-V datapath. It decodes the ID-stage opcode into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, which stall the front end and insert a bubble, and squashes wrong-path instructions when EX resolves a taken branch or jump. It sits beside the ID stage and feeds the EX, MEM and WB datapath muxes directly.

## Interface
- REG_ADDR_W, 5, register-index width
- ALUOP_W, 2, ALUOp width seen by the ALU control block
- ENABLE_JUMP, 1, when 1 decode JAL/JALR; when 0 treat them as illegal
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, all state in this domain
- id_opcode  in  7  opcode of the instruction in ID
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register fields of the ID instruction
- ex_redirect  in  1  branch taken or jump, resolved in EX this cycle
- ex_alu_op  out  ALUOP_W;  ex_alu_src, ex_branch, ex_jump  out  1 each
- ex_rd  out  REG_ADDR_W;  ex_illegal  out  1
- mem_mem_read, mem_mem_write  out  1;  mem_rd  out  REG_ADDR_W
- wb_reg_write, wb_mem_to_reg, wb_link  out  1;  wb_rd  out  REG_ADDR_W
- pc_write, ifid_write, ifid_flush  out  1  front-end control (combinational)

## Operation
- Decode, per opcode: branch / memRead / memToReg / memWrite / ALUSrc / regWrite / link / ALUOp.
  - R 0110011: 0/0/0/0/0/1/0/10
  - LD 0000011: 0/1/1/0/1/1/0/00
  - I-ALU 0010011: 0/0/0/0/1/1/0/11. ALUOp 11 means "use funct3, immediate form", so slli is decoded correctly.
  - SD 0100011: 0/0/0/1/1/0/0/00
  - SB 1100011: 1/0/0/0/0/0/0/01
  - JAL 1101111 / JALR 1100111 (ENABLE_JUMP=1): jump=1, regWrite=1, link=1, ALUSrc=1, ALUOp 00
- Any other opcode: all controls 0 and illegal=1.
- regWrite is forced to 0 when rd==0.
- Register usage:
  - rs1 is used by every opcode except JAL and illegal.
  - rs2 is used only by R, SD and SB.
- Load-use hazard, stall=1 when all of the following hold:
  - ex_mem_read_q=1
  - ex_rd!=0
  - ex_rd equals a *used* ID source register
- On stall:
  - pc_write=0 and ifid_write=0.
  - The ID/EX register loads a bubble (all controls 0, rd=0, illegal=0).
- On flush (ex_redirect=1):
  - ifid_flush=1.
  - The ID/EX register loads a bubble.
  - pc_write=1 and ifid_write=1.
- Stall and flush in the same cycle: flush wins, stall is ignored.
- EX/MEM and MEM/WB always advance; they are never stalled.

## Timing
- Control for the instruction in ID at cycle n appears on ex_* at n+1, mem_* at n+2 and wb_* at n+3.
- A stalled instruction re-decodes next cycle and leaves a single-cycle bubble. The stall deasserts after one cycle because the load has moved to MEM.
- pc_write, ifid_write and ifid_flush are combinational from the current inputs and the ID/EX register state, with no added latency.
- Reset, synchronous at the clock edge:
  - All pipeline registers are cleared to bubble.
  - Every ex_*, mem_* and wb_* output is 0.
  - pc_write=1, ifid_write=1, ifid_flush=0 during and after reset.
- Reset mid-operation discards all in-flight control. No partial bubble remains after the first post-reset edge.

## Structure
- The shared package ctrl_pkg holds:
  - opcode localparams
  - ALUOp encodings (ADD=00, BR=01, R=10, I=11)
  - a packed ctrl_t bundle struct with a CTRL_BUBBLE constant
- One combinational sub-module, ctrl_decoder, maps opcode to {ctrl_t, illegal, uses_rs1, uses_rs2}.
- The top level holds the three stage registers plus the hazard and flush logic.

## Test plan
- Reset, then R add x3,x1,x2: ex_alu_op=10 at n+1; wb_reg_write=1, wb_rd=3 at n+3.
- ld x5 then add x6,x5,x1 back-to-back: in one cycle pc_write=0, ifid_write=0; the next ex_* is a bubble; the add reaches EX one cycle later.
- ld x5 then SB with rs2=x5: stall. ld x5 then JAL: no stall. ld x0 then use of x0: no stall.
- ex_redirect=1 while a load-use stall is also pending: ifid_flush=1, pc_write=1, ID/EX gets a bubble.
- Opcode 0110111 (unknown) or JAL with ENABLE_JUMP=0: ex_illegal=1 and all controls 0. addi x0: wb_reg_write=0.
- Assert reset in the cycle a load sits in MEM: mem_mem_read=0 and all wb_* are 0 after the edge.
